// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate datapath slice.
package mac_pkg;

  // Controller states: gathering terms, or holding a finished result.
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } mac_state_e;

  localparam int PROD_W_DEF    = 12;
  localparam int ACC_W_DEF     = 16;
  localparam int MAX_TERMS_DEF = 16;

endpackage

// File: rtl/acc_adder.sv
// Accumulator adder: ACC_W/4 CLA4 slices chained through their carries.
module acc_adder #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry_out
);

  localparam int SLICES = ACC_W / 4;

  logic [SLICES:0] carry;

  assign carry[0]  = 1'b0;
  assign carry_out = carry[SLICES];

  for (genvar i = 0; i < SLICES; i++) begin : g_slice
    cla4 u_slice (
      .a    (a[4*i +: 4]),
      .b    (b[4*i +: 4]),
      .cin  (carry[i]),
      .sum  (sum[4*i +: 4]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice, the building block of the wider adders.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [3:0] carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Every carry is formed directly from generate/propagate terms, so no ripple inside a slice.
  always_comb begin
    carry[0] = cin;
    carry[1] = gen[0] | (prop[0] & cin);
    carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
    carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & cin);
    cout     = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & cin);
    sum      = prop ^ carry;
  end

endmodule

// File: rtl/mac_accumulator.sv
// Sums groups of multiplier products and hands each group's total downstream.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF,
  localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  input  logic              clear,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf,
  output logic              acc_valid,
  input  logic              acc_ready
);

  mac_state_e       state;
  mac_state_e       next_state;
  logic             accept;
  logic             last_term;
  logic [ACC_W-1:0] sum;
  logic             carry_out;

  acc_adder #(
    .ACC_W (ACC_W)
  ) u_adder (
    .a         (acc_out),
    .b         (ACC_W'(prod)),
    .sum       (sum),
    .carry_out (carry_out)
  );

  // The result is valid exactly while the controller holds it in DONE.
  assign acc_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= next_state;
    end
  end

  // Handshake decode and next state; prod_ready never looks at prod_valid.
  always_comb begin
    next_state = state;
    prod_ready = (state == ACCUM) && !clear;
    accept     = prod_ready && prod_valid;
    last_term  = prod_last || (acc_count == CNT_W'(MAX_TERMS - 1));
    case (state)
      ACCUM: if (accept && last_term) next_state = DONE;
      DONE:  if (acc_ready)           next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
    if (clear) next_state = ACCUM;
  end

  // Accumulator, term count and sticky overflow; zeroed on clear and on result handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out   <= '0;
      acc_count <= '0;
      acc_ovf   <= 1'b0;
    end else if (clear || (state == DONE && acc_ready)) begin
      acc_out   <= '0;
      acc_count <= '0;
      acc_ovf   <= 1'b0;
    end else if (accept) begin
      acc_out   <= sum;
      acc_count <= acc_count + CNT_W'(1);
      acc_ovf   <= acc_ovf | carry_out;
    end
  end

endmodule
